// File: rtl/hart_issue_scheduler_if.sv
// Issue-scheduler bus: thread control inputs in, issue/status outputs back.
// Optional macro SCHED_PERF_CNT_EN adds the performance counter outputs.
interface hart_issue_scheduler_if #(
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned TID_WIDTH   = $clog2(NUM_THREADS)
);
  logic [NUM_THREADS-1:0] enable_mask_i;
  logic                   stall_i;
  logic                   park_valid_i;
  logic [TID_WIDTH-1:0]   park_tid_i;
  logic [NUM_THREADS-1:0] wake_i;
  logic                   issue_valid_o;
  logic [TID_WIDTH-1:0]   issue_tid_o;
  logic [NUM_THREADS-1:0] active_o;
  logic                   idle_o;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]            issue_count_o;
  logic [31:0]            bubble_count_o;

  modport master (
    output enable_mask_i, stall_i, park_valid_i, park_tid_i, wake_i,
    input  issue_valid_o, issue_tid_o, active_o, idle_o,
    input  issue_count_o, bubble_count_o
  );
  modport slave (
    input  enable_mask_i, stall_i, park_valid_i, park_tid_i, wake_i,
    output issue_valid_o, issue_tid_o, active_o, idle_o,
    output issue_count_o, bubble_count_o
  );
`else
  modport master (
    output enable_mask_i, stall_i, park_valid_i, park_tid_i, wake_i,
    input  issue_valid_o, issue_tid_o, active_o, idle_o
  );
  modport slave (
    input  enable_mask_i, stall_i, park_valid_i, park_tid_i, wake_i,
    output issue_valid_o, issue_tid_o, active_o, idle_o
  );
`endif
endinterface

// File: rtl/hart_issue_scheduler.sv
// Round-robin barrel-thread issue scheduler with per-thread re-issue spacing,
// WFI park/wake and software enables. Optional macro SCHED_PERF_CNT_EN adds
// issue/bubble performance counters.
module hart_issue_scheduler #(
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned PIPE_DEPTH  = 16
) (
  input logic                   clk,
  input logic                   reset,
  hart_issue_scheduler_if.slave bus
);
  localparam int unsigned TID_WIDTH = $clog2(NUM_THREADS);
  localparam logic [5:0]  RELOAD    = 6'(PIPE_DEPTH - 1);

  typedef enum logic [1:0] {OFF, READY, INFLIGHT, PARKED} thr_state_t;

  thr_state_t             st_q  [NUM_THREADS];
  thr_state_t             st_d  [NUM_THREADS];
  logic [5:0]             cnt_q [NUM_THREADS];
  logic [5:0]             cnt_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] pend_q, pend_d;
  logic [NUM_THREADS-1:0] eligible, active_d;
  logic [TID_WIDTH-1:0]   rr_ptr_q, sel_tid, idx;
  logic                   sel_valid, park_t, wake_t, pend_t;

  function automatic thr_state_t retire(input logic pend, input logic en);
    if (pend)     return PARKED;
    else if (!en) return OFF;
    else          return READY;
  endfunction

  // Threads that may be picked this cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++)
      eligible[t] = (st_q[t] == READY) && bus.enable_mask_i[t];
  end

  // Round-robin pick of the first eligible thread after rr_ptr.
  always_comb begin
    sel_valid = 1'b0;
    sel_tid   = rr_ptr_q;
    idx       = '0;
    if (!bus.stall_i) begin
      for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
        idx = rr_ptr_q + TID_WIDTH'(k);
        if (!sel_valid && eligible[idx]) begin
          sel_valid = 1'b1;
          sel_tid   = idx;
        end
      end
    end
  end

  // Per-thread next state, countdown and park-pending flag.
  // The INFLIGHT exit fires on the cycle the countdown would reach zero, so
  // the thread is READY again exactly PIPE_DEPTH non-stalled cycles after it
  // was picked; PIPE_DEPTH=1 never enters INFLIGHT at all.
  always_comb begin
    park_t   = 1'b0;
    wake_t   = 1'b0;
    pend_t   = 1'b0;
    pend_d   = pend_q;
    active_d = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      st_d[t]  = st_q[t];
      cnt_d[t] = cnt_q[t];
      park_t   = bus.park_valid_i && (bus.park_tid_i == TID_WIDTH'(t));
      wake_t   = bus.wake_i[t];
      pend_t   = 1'b0;
      case (st_q[t])
        OFF: begin
          if (bus.enable_mask_i[t]) st_d[t] = READY;
        end
        READY: begin
          if (!bus.enable_mask_i[t]) begin
            st_d[t] = OFF;
          end else if (sel_valid && (sel_tid == TID_WIDTH'(t))) begin
            pend_t = park_t && !wake_t;
            if (RELOAD == 6'd0) begin
              st_d[t]   = retire(pend_t, 1'b1);
              pend_d[t] = 1'b0;
            end else begin
              st_d[t]   = INFLIGHT;
              cnt_d[t]  = RELOAD;
              pend_d[t] = pend_t;
            end
          end else if (park_t && !wake_t) begin
            st_d[t] = PARKED;
          end
        end
        INFLIGHT: begin
          pend_t    = !wake_t && (park_t || pend_q[t]);
          pend_d[t] = pend_t;
          if (!bus.stall_i) begin
            if (cnt_q[t] <= 6'd1) begin
              st_d[t]   = retire(pend_t, bus.enable_mask_i[t]);
              cnt_d[t]  = '0;
              pend_d[t] = 1'b0;
            end else begin
              cnt_d[t] = cnt_q[t] - 6'd1;
            end
          end
        end
        PARKED: begin
          if (!bus.enable_mask_i[t]) st_d[t] = OFF;
          else if (wake_t)           st_d[t] = READY;
        end
        default: st_d[t] = OFF;
      endcase
      active_d[t] = (st_d[t] == READY) || (st_d[t] == INFLIGHT);
    end
  end

  // State registers and registered issue/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        st_q[t]  <= OFF;
        cnt_q[t] <= '0;
      end
      pend_q            <= '0;
      rr_ptr_q          <= '1;
      bus.issue_valid_o <= 1'b0;
      bus.issue_tid_o   <= '0;
      bus.active_o      <= '0;
      bus.idle_o        <= 1'b1;
    end else begin
      st_q              <= st_d;
      cnt_q             <= cnt_d;
      pend_q            <= pend_d;
      bus.issue_valid_o <= sel_valid;
      if (sel_valid) begin
        rr_ptr_q        <= sel_tid;
        bus.issue_tid_o <= sel_tid;
      end
      bus.active_o <= active_d;
      bus.idle_o   <= ~|active_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic any_on;

  // Any thread not OFF makes an empty non-stalled slot count as a bubble.
  always_comb begin
    any_on = 1'b0;
    for (int unsigned t = 0; t < NUM_THREADS; t++)
      if (st_q[t] != OFF) any_on = 1'b1;
  end

  // Free-running wrap-around issue and bubble counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.issue_count_o  <= '0;
      bus.bubble_count_o <= '0;
    end else begin
      if (bus.issue_valid_o)
        bus.issue_count_o <= bus.issue_count_o + 32'd1;
      if (!bus.stall_i && !bus.issue_valid_o && any_on)
        bus.bubble_count_o <= bus.bubble_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hart_issue_scheduler.sv
// Directed bench for hart_issue_scheduler (16 threads, 16-deep spacing).
module tb_hart_issue_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  hart_issue_scheduler_if #(.NUM_THREADS(16)) bus ();

  hart_issue_scheduler #(.NUM_THREADS(16), .PIPE_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [15:0] en);
    reset             = 1'b1;
    bus.enable_mask_i = en;
    bus.stall_i       = 1'b0;
    bus.park_valid_i  = 1'b0;
    bus.park_tid_i    = 4'd0;
    bus.wake_i        = 16'h0;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    do_reset(16'h0);
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.issue_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.issue_valid_o); end
    n_cmp++; if (bus.issue_tid_o !== 4'd0) begin n_err++; $display("FAIL rst_tid: got %0d want 0", bus.issue_tid_o); end
    n_cmp++; if (bus.active_o !== 16'h0) begin n_err++; $display("FAIL rst_active: got %h want 0000", bus.active_o); end
    n_cmp++; if (bus.idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", bus.idle_o); end
    reset = 1'b0;
    cyc = 0;
    repeat (4) tick();
    n_cmp++; if (bus.idle_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin
      n_err++; $display("FAIL none_enabled: idle %b valid %b want idle 1 valid 0", bus.idle_o, bus.issue_valid_o);
    end
  endtask

  task automatic test_all_enabled();
    int exp_tid;
    do_reset(16'hFFFF);
    tick();
    n_cmp++; if (bus.issue_valid_o !== 1'b0) begin n_err++; $display("FAIL all_first_cycle: valid %b want 0", bus.issue_valid_o); end
    n_cmp++; if (bus.active_o !== 16'hFFFF || bus.idle_o !== 1'b0) begin
      n_err++; $display("FAIL all_active: active %h idle %b want ffff 0", bus.active_o, bus.idle_o);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_tid = (cyc - 2) % 16;
      n_cmp++; if (bus.issue_valid_o !== 1'b1 || bus.issue_tid_o !== 4'(exp_tid)) begin
        n_err++; $display("FAIL all_seq cyc %0d: valid %b tid %0d want 1 %0d", cyc, bus.issue_valid_o, bus.issue_tid_o, exp_tid);
      end
    end
  endtask

  task automatic test_single();
    logic exp_v;
    do_reset(16'h0001);
    for (int i = 0; i < 34; i++) begin
      tick();
      exp_v = (cyc >= 2) && (((cyc - 2) % 16) == 0);
      n_cmp++; if (bus.issue_valid_o !== exp_v) begin
        n_err++; $display("FAIL single_valid cyc %0d: got %b want %b", cyc, bus.issue_valid_o, exp_v);
      end
      if (exp_v) begin
        n_cmp++; if (bus.issue_tid_o !== 4'd0) begin n_err++; $display("FAIL single_tid cyc %0d: got %0d want 0", cyc, bus.issue_tid_o); end
      end
      if (cyc == 10) begin
        n_cmp++; if (bus.idle_o !== 1'b0 || bus.active_o !== 16'h0001) begin
          n_err++; $display("FAIL single_status: idle %b active %h want 0 0001", bus.idle_o, bus.active_o);
        end
      end
    end
  endtask

  task automatic test_stall();
    int exp_tid;
    do_reset(16'hFFFF);
    for (int i = 0; i < 26; i++) begin
      bus.stall_i = (cyc >= 5) && (cyc <= 9);
      tick();
      if (cyc >= 6 && cyc <= 10) begin
        n_cmp++; if (bus.issue_valid_o !== 1'b0 || bus.issue_tid_o !== 4'd3) begin
          n_err++; $display("FAIL stall_hold cyc %0d: valid %b tid %0d want 0 3", cyc, bus.issue_valid_o, bus.issue_tid_o);
        end
      end else if (cyc >= 2) begin
        exp_tid = (cyc <= 5) ? (cyc - 2) : ((cyc - 7) % 16);
        n_cmp++; if (bus.issue_valid_o !== 1'b1 || bus.issue_tid_o !== 4'(exp_tid)) begin
          n_err++; $display("FAIL stall_seq cyc %0d: valid %b tid %0d want 1 %0d", cyc, bus.issue_valid_o, bus.issue_tid_o, exp_tid);
        end
      end
    end
    bus.stall_i = 1'b0;
  endtask

  task automatic test_park_wake();
    logic exp_v;
    logic [3:0] exp_t;
    do_reset(16'h0003);
    for (int i = 0; i < 50; i++) begin
      bus.park_valid_i = (cyc == 3) || (cyc == 28);
      bus.park_tid_i   = 4'd1;
      bus.wake_i       = ((cyc == 25) || (cyc == 28)) ? 16'h0002 : 16'h0000;
      tick();
      exp_v = (cyc == 2) || (cyc == 3) || (cyc == 18) || (cyc == 27) ||
              (cyc == 34) || (cyc == 43) || (cyc == 50);
      exp_t = ((cyc == 3) || (cyc == 27) || (cyc == 43)) ? 4'd1 : 4'd0;
      n_cmp++; if (bus.issue_valid_o !== exp_v) begin
        n_err++; $display("FAIL park_valid cyc %0d: got %b want %b", cyc, bus.issue_valid_o, exp_v);
      end
      if (exp_v) begin
        n_cmp++; if (bus.issue_tid_o !== exp_t) begin
          n_err++; $display("FAIL park_tid cyc %0d: got %0d want %0d", cyc, bus.issue_tid_o, exp_t);
        end
      end
      if (cyc == 18) begin
        n_cmp++; if (bus.active_o !== 16'h0001) begin n_err++; $display("FAIL parked_active: got %h want 0001", bus.active_o); end
      end
      if (cyc == 26) begin
        n_cmp++; if (bus.active_o !== 16'h0003) begin n_err++; $display("FAIL woken_active: got %h want 0003", bus.active_o); end
      end
    end
    bus.park_valid_i = 1'b0;
    bus.wake_i       = 16'h0;
  endtask

  task automatic test_disable_reset();
    do_reset(16'hFFFF);
    for (int i = 0; i < 24; i++) begin
      bus.enable_mask_i = (cyc >= 8) ? 16'hFFDF : 16'hFFFF;
      tick();
      if (cyc == 7) begin
        n_cmp++; if (bus.issue_tid_o !== 4'd5) begin n_err++; $display("FAIL dis_tid5: got %0d want 5", bus.issue_tid_o); end
      end
      if (cyc == 21) begin
        n_cmp++; if (bus.active_o[5] !== 1'b1) begin n_err++; $display("FAIL dis_inflight: active5 %b want 1", bus.active_o[5]); end
      end
      if (cyc == 22) begin
        n_cmp++; if (bus.active_o !== 16'hFFDF) begin n_err++; $display("FAIL dis_off: active %h want ffdf", bus.active_o); end
        n_cmp++; if (bus.issue_valid_o !== 1'b1 || bus.issue_tid_o !== 4'd4) begin
          n_err++; $display("FAIL dis_c22: valid %b tid %0d want 1 4", bus.issue_valid_o, bus.issue_tid_o);
        end
      end
      if (cyc == 23) begin
        n_cmp++; if (bus.issue_valid_o !== 1'b0 || bus.issue_tid_o !== 4'd4) begin
          n_err++; $display("FAIL dis_gap: valid %b tid %0d want 0 4", bus.issue_valid_o, bus.issue_tid_o);
        end
      end
      if (cyc == 24) begin
        n_cmp++; if (bus.issue_valid_o !== 1'b1 || bus.issue_tid_o !== 4'd6) begin
          n_err++; $display("FAIL dis_skip: valid %b tid %0d want 1 6", bus.issue_valid_o, bus.issue_tid_o);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.issue_valid_o !== 1'b0 || bus.issue_tid_o !== 4'd0) begin
      n_err++; $display("FAIL midrst_issue: valid %b tid %0d want 0 0", bus.issue_valid_o, bus.issue_tid_o);
    end
    n_cmp++; if (bus.active_o !== 16'h0 || bus.idle_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_status: active %h idle %b want 0000 1", bus.active_o, bus.idle_o);
    end
    tick();
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_perf();
    do_reset(16'h0001);
    n_cmp++; if (bus.issue_count_o !== 32'd0 || bus.bubble_count_o !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: issue %0d bubble %0d want 0 0", bus.issue_count_o, bus.bubble_count_o);
    end
    repeat (33) tick();
    n_cmp++; if (bus.issue_count_o !== 32'd2) begin n_err++; $display("FAIL perf_issue: got %0d want 2", bus.issue_count_o); end
    n_cmp++; if (bus.bubble_count_o !== 32'd30) begin n_err++; $display("FAIL perf_bubble: got %0d want 30", bus.bubble_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_enabled();
    test_single();
    test_stall();
    test_park_wake();
    test_disable_reset();
`ifdef SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
